// File: rtl/pcu_pkg.sv
// Shared types and helpers for the program-counter fetch unit.
package pcu_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } pcu_state_e;

  // Bytes covered by one fetch packet.
  function automatic int unsigned fetch_bytes(input int unsigned fetch_width);
    return fetch_width * 4;
  endfunction

  // Number of address bits below the packet boundary (log2 of fetch_bytes).
  function automatic int unsigned off_width(input int unsigned fetch_width);
    return $clog2(fetch_width * 4);
  endfunction

  // Lane `lane` holds a fetch-target instruction when it is at or above the entry lane.
  function automatic logic lane_mask_bit(input logic [2:0] entry_lane, input int unsigned lane);
    return lane >= 32'(entry_lane);
  endfunction

endpackage

// File: rtl/pcu_lane_mask.sv
// Combinational entry-lane offset to thermometer lane mask.
module pcu_lane_mask
  import pcu_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2
) (
  input  logic [2:0]             offset,
  output logic [FETCH_WIDTH-1:0] mask
);

  // Every lane at or above the entry lane carries a live instruction.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      mask[i] = lane_mask_bit(offset, i);
    end
  end

endmodule

// File: rtl/pcu_fetch_gen.sv
// Program-counter unit producing aligned multi-lane fetch packets with a
// valid/ready handshake, redirect epochs and a halt state.
// Optional feature macro: PCU_MISALIGN_CHK_EN (adds fault_o and rejects
// redirect targets that are not 4-byte aligned).
module pcu_fetch_gen
  import pcu_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     FETCH_WIDTH = 2,
  parameter logic [XLEN-1:0] RESET_ADDR  = '0,
  parameter int unsigned     EPOCH_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid_i,
  input  logic [XLEN-1:0]        redirect_addr_i,
  input  logic                   halt_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [XLEN-1:0]        instAddr_o,
  output logic [FETCH_WIDTH-1:0] laneMask_o,
  output logic [EPOCH_W-1:0]     epoch_o
`ifdef PCU_MISALIGN_CHK_EN
  ,
  output logic                   fault_o
`endif
);

  localparam int unsigned     FetchBytes = fetch_bytes(FETCH_WIDTH);
  localparam logic [XLEN-1:0] AlignMask  = ~XLEN'(FetchBytes - 1);
  localparam logic [XLEN-1:0] InstMask   = ~XLEN'(3);

  pcu_state_e             state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [EPOCH_W-1:0]     epoch_q, epoch_d;
  logic [FETCH_WIDTH-1:0] mask_q, mask_d, lane_mask;
  logic [2:0]             lane_off_d;
  logic                   fire;
`ifdef PCU_MISALIGN_CHK_EN
  logic                   fault_q, fault_d;
`endif

  assign valid_o    = (state_q == S_RUN);
  assign instAddr_o = pc_q & AlignMask;
  assign laneMask_o = mask_q;
  assign epoch_o    = epoch_q;
  assign fire       = valid_o & ready_i;
`ifdef PCU_MISALIGN_CHK_EN
  assign fault_o    = fault_q;
`endif

  // Next state: redirect beats halt, halt beats advance, otherwise hold.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
`ifdef PCU_MISALIGN_CHK_EN
    fault_d = 1'b0;
`endif
    if (redirect_valid_i) begin
      epoch_d = epoch_q + EPOCH_W'(1);
`ifdef PCU_MISALIGN_CHK_EN
      if (redirect_addr_i[1:0] != 2'b00) begin
        // Rejected target: park until software supplies an aligned redirect.
        fault_d = 1'b1;
        state_d = S_HALT;
      end else begin
        pc_d    = redirect_addr_i & InstMask;
        state_d = S_RUN;
      end
`else
      pc_d    = redirect_addr_i & InstMask;
      state_d = S_RUN;
`endif
    end else begin
      unique case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          // A packet accepted alongside halt still advances the pc.
          if (fire) pc_d = instAddr_o + XLEN'(FetchBytes);
          if (halt_i) state_d = S_HALT;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_BOOT;
      endcase
    end
  end

  assign lane_off_d = 3'((pc_d & ~AlignMask) >> 2);

  pcu_lane_mask #(
    .FETCH_WIDTH(FETCH_WIDTH)
  ) u_lane_mask (
    .offset(lane_off_d),
    .mask  (lane_mask)
  );

  // Mask is only meaningful for a valid packet.
  assign mask_d = (state_d == S_RUN) ? lane_mask : '0;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_ADDR;
      epoch_q <= '0;
      mask_q  <= '0;
`ifdef PCU_MISALIGN_CHK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      mask_q  <= mask_d;
`ifdef PCU_MISALIGN_CHK_EN
      fault_q <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_pcu_fetch_gen.sv
// Self-checking bench for pcu_fetch_gen: directed literal scenarios followed
// by randomized traffic compared every cycle against a behavioural model.
module tb_pcu_fetch_gen;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FW    = 2;
  localparam int unsigned FB    = FW * 4;
  localparam logic [31:0] RADDR = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid_i = 1'b0;
  logic [31:0]   redirect_addr_i = '0;
  logic          halt_i = 1'b0;
  logic          ready_i = 1'b1;
  logic          valid_o;
  logic [31:0]   instAddr_o;
  logic [FW-1:0] laneMask_o;
  logic [1:0]    epoch_o;
  logic          fault_w;

  pcu_fetch_gen #(
    .XLEN       (XLEN),
    .FETCH_WIDTH(FW),
    .RESET_ADDR (RADDR),
    .EPOCH_W    (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid_i(redirect_valid_i),
    .redirect_addr_i (redirect_addr_i),
    .halt_i          (halt_i),
    .ready_i         (ready_i),
    .valid_o         (valid_o),
    .instAddr_o      (instAddr_o),
    .laneMask_o      (laneMask_o),
    .epoch_o         (epoch_o)
`ifdef PCU_MISALIGN_CHK_EN
    ,
    .fault_o         (fault_w)
`endif
  );

`ifndef PCU_MISALIGN_CHK_EN
  assign fault_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: mode 0 = booting, 1 = fetching, 2 = halted.
  int          m_mode  = 0;
  logic [31:0] m_pc    = RADDR;
  int          m_epoch = 0;
  bit          m_fault = 1'b0;
  bit          chk_en_cfg;

  initial begin
`ifdef PCU_MISALIGN_CHK_EN
    chk_en_cfg = 1'b1;
`else
    chk_en_cfg = 1'b0;
`endif
  end

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_pc = RADDR; m_epoch = 0; m_fault = 0;
    end else begin
      m_fault = 0;
      if (redirect_valid_i) begin
        m_epoch = (m_epoch + 1) % 4;
        if (chk_en_cfg && (redirect_addr_i % 4 != 0)) begin
          m_fault = 1; m_mode = 2;
        end else begin
          m_pc = redirect_addr_i - (redirect_addr_i % 4); m_mode = 1;
        end
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (ready_i) m_pc = m_pc - (m_pc % FB) + FB;
        if (halt_i) m_mode = 2;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      logic [FW-1:0] emask;
      for (int i = 0; i < FW; i++) emask[i] = (m_mode == 1) && (i >= (m_pc % FB) / 4);
      check("m_valid", 32'(valid_o), 32'(m_mode == 1));
      check("m_addr", instAddr_o, m_pc - (m_pc % FB));
      check("m_mask", 32'(laneMask_o), 32'(emask));
      check("m_epoch", 32'(epoch_o), 32'(m_epoch));
      check("m_fault", 32'(fault_w), 32'(m_fault));
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic pkt(input string name, input logic v, input logic [31:0] a,
                     input logic [1:0] m, input logic [1:0] e);
    check({name, "_valid"}, 32'(valid_o), 32'(v));
    if (v) check({name, "_addr"}, instAddr_o, a);
    check({name, "_mask"}, 32'(laneMask_o), 32'(m));
    check({name, "_epoch"}, 32'(epoch_o), 32'(e));
  endtask

  initial begin
    // 1: reset state, then streaming from the boot vector.
    step(); check_en = 1'b1; step();
    pkt("rst", 1'b0, 32'h0, 2'b00, 2'd0);
    check("rst_addr", instAddr_o, 32'h8000_0000);
    reset = 1'b0;
    step(); pkt("boot0", 1'b1, 32'h8000_0000, 2'b11, 2'd0);
    step(); pkt("boot1", 1'b1, 32'h8000_0008, 2'b11, 2'd0);
    step(); pkt("boot2", 1'b1, 32'h8000_0010, 2'b11, 2'd0);
    // 2: back-pressure holds the packet.
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); pkt("stall", 1'b1, 32'h8000_0010, 2'b11, 2'd0);
    end
    ready_i = 1'b1;
    step(); pkt("unstall", 1'b1, 32'h8000_0018, 2'b11, 2'd0);
    // 3: redirect while stalled drops the packet; partial mask at entry.
    ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_addr_i = 32'h8000_1004;
    step(); pkt("redir", 1'b1, 32'h8000_1000, 2'b10, 2'd1);
    redirect_valid_i = 1'b0; ready_i = 1'b1;
    step(); pkt("redir_next", 1'b1, 32'h8000_1008, 2'b11, 2'd1);
    // 4: halt together with fire, halt is sticky until redirect.
    redirect_valid_i = 1'b1; redirect_addr_i = 32'h8000_0010;
    step(); pkt("pre_halt", 1'b1, 32'h8000_0010, 2'b11, 2'd2);
    redirect_valid_i = 1'b0; halt_i = 1'b1;
    step(); pkt("halt0", 1'b0, 32'h0, 2'b00, 2'd2);
    step(); pkt("halt1", 1'b0, 32'h0, 2'b00, 2'd2);
    halt_i = 1'b0;
    step(); pkt("halt2", 1'b0, 32'h0, 2'b00, 2'd2);
    check("halt_pc", instAddr_o, 32'h8000_0018);
    redirect_valid_i = 1'b1; redirect_addr_i = 32'h8000_2000;
    step(); pkt("unhalt", 1'b1, 32'h8000_2000, 2'b11, 2'd3);
    // 5: mid-run reset, back-to-back redirects, address wrap.
    redirect_valid_i = 1'b0; reset = 1'b1;
    step(); pkt("rst2", 1'b0, 32'h0, 2'b00, 2'd0);
    reset = 1'b0;
    step(); pkt("reboot", 1'b1, 32'h8000_0000, 2'b11, 2'd0);
    redirect_valid_i = 1'b1; redirect_addr_i = 32'h8000_3000;
    step(); pkt("rd1", 1'b1, 32'h8000_3000, 2'b11, 2'd1);
    redirect_addr_i = 32'h1234_567C;
    step(); pkt("rd2", 1'b1, 32'h1234_5678, 2'b10, 2'd2);
    redirect_addr_i = 32'hFFFF_FFF8;
    step(); pkt("rd3", 1'b1, 32'hFFFF_FFF8, 2'b11, 2'd3);
    redirect_addr_i = 32'hFFFF_FFF8;
    step(); pkt("rd4", 1'b1, 32'hFFFF_FFF8, 2'b11, 2'd0);
    redirect_valid_i = 1'b0;
    step(); pkt("wrap", 1'b1, 32'h0000_0000, 2'b11, 2'd0);
    // 6: misaligned redirect target.
    redirect_valid_i = 1'b1; redirect_addr_i = 32'h8000_0302;
    step();
    redirect_valid_i = 1'b0;
`ifdef PCU_MISALIGN_CHK_EN
    pkt("misal", 1'b0, 32'h0, 2'b00, 2'd1);
    check("misal_fault", 32'(fault_w), 32'd1);
    step(); check("misal_fault_clr", 32'(fault_w), 32'd0);
    check("misal_stay", 32'(valid_o), 32'd0);
`else
    pkt("misal", 1'b1, 32'h8000_0300, 2'b11, 2'd1);
`endif
    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset            = ($urandom_range(0, 99) == 0);
      redirect_valid_i = ($urandom_range(0, 7) == 0);
      redirect_addr_i  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                      : $urandom;
      halt_i           = ($urandom_range(0, 9) == 0);
      ready_i          = ($urandom_range(0, 9) < 7);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcu_fetch_gen.md
# pcu_fetch_gen

Parametrised program-counter unit generating aligned multi-lane fetch packets for the front end. It sits between the redirect sources (branch unit, trap logic) and the instruction fetch stage. It generalises the per-way PC generator in three ways:
- configurable fetch width, address width and reset vector;
- a true valid/ready handshake with redirect priority;
- a redirect epoch tag, a halt state and per-lane valid masks.

## Interface
Parameters:
- XLEN, 32, address width in bits
- FETCH_WIDTH, 2, 32-bit instruction lanes per packet; power of two, 1..8
- RESET_ADDR, 32'h0000_0000, boot address; must be 4-byte aligned
- EPOCH_W, 2, width of redirect epoch tag

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- redirect_valid_i  input  1  redirect request this cycle
- redirect_addr_i  input  XLEN  redirect target
- halt_i  input  1  stop fetching (fence/wfi) until next redirect
- ready_i  input  1  fetch stage accepts packet
- valid_o  output  1  packet valid
- instAddr_o  output  XLEN  packet base address, aligned to FETCH_WIDTH*4 bytes
- laneMask_o  output  FETCH_WIDTH  bit i set = lane i holds a fetch-target instruction
- epoch_o  output  EPOCH_W  epoch of current packet
- fault_o  output  1  misaligned redirect target (only with PCU_MISALIGN_CHK_EN)

## Operation
- FETCH_BYTES = FETCH_WIDTH*4.
- Internal pc_q tracks the current fetch target.
- instAddr_o = pc_q with log2(FETCH_BYTES) LSBs cleared.
- laneMask_o bit i = 1 for i >= pc_q[log2(FETCH_BYTES)-1:2]. It is 0 whenever valid_o = 0.
- fire = valid_o & ready_i.
- States:
  - S_BOOT (reset state, valid_o=0)
  - S_RUN (valid_o=1)
  - S_HALT (valid_o=0)
- Transitions: S_BOOT -> S_RUN unconditionally. S_RUN -> S_HALT on halt_i without redirect. S_HALT -> S_RUN on redirect only. In S_HALT, halt_i is ignored.
- Priority per edge: reset > redirect > halt_i > fire-advance > hold.
- Redirect (any state):
  - pc_q <= redirect_addr_i with [1:0] cleared.
  - epoch_o increments modulo 2^EPOCH_W.
  - Next state is S_RUN.
  - Any un-accepted packet is dropped.
- Fire without redirect or halt: pc_q <= instAddr_o + FETCH_BYTES, i.e. the next packet is fully aligned with an all-ones mask. The address wraps modulo 2^XLEN.
- valid_o & ~ready_i without redirect or halt: instAddr_o, laneMask_o and epoch_o are held stable.
- halt_i with fire in the same cycle: the current packet counts as accepted. The next state is S_HALT and pc_q advances.

## Timing
- Reset values:
  - valid_o=0, instAddr_o = RESET_ADDR aligned down, laneMask_o=0, epoch_o=0, fault_o=0.
  - pc_q=RESET_ADDR, state S_BOOT.
- First packet: valid_o=1 one cycle after the first edge with reset low.
- Redirect latency: 1 cycle. A request sampled at edge N is visible as the new packet after edge N, independent of ready_i.
- Halt latency: 1 cycle. valid_o=0 after the edge sampling halt_i.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset asserted mid-operation overrides everything on that edge: pending packet and epoch are discarded, and the block returns to S_BOOT.

## Configuration
- PCU_MISALIGN_CHK_EN defined:
  - A redirect with redirect_addr_i[1:0] != 0 does not redirect.
  - fault_o pulses 1 for one cycle, state -> S_HALT, and epoch increments.
  - Recovery requires a subsequent aligned redirect.
- PCU_MISALIGN_CHK_EN undefined:
  - fault_o port is absent.
  - Target bits [1:0] are silently cleared and the redirect proceeds.

## Structure
- Package pcu_pkg: state enum (S_BOOT, S_RUN, S_HALT), fetch_bytes/offset-width helper functions, lane-mask function.
- Sub-module pcu_lane_mask: combinational offset -> FETCH_WIDTH-bit thermometer mask. It is instantiated once and its output is registered in the parent.

## Test plan
Config for all scenarios: FETCH_WIDTH=2, XLEN=32, RESET_ADDR=32'h8000_0000, EPOCH_W=2.
1. Release reset, ready_i=1 -> valid_o=1 one cycle after release. instAddr_o sequence 8000_0000, 8000_0008, 8000_0010; laneMask_o=2'b11.
2. ready_i=0 for 3 cycles mid-stream -> instAddr_o, laneMask_o and epoch_o stable. On ready_i=1, advance by 8.
3. Redirect to 8000_1004 while valid_o & ~ready_i -> next cycle instAddr_o=8000_1000, laneMask_o=2'b10, epoch_o=1. Then 8000_1008 with mask 2'b11.
4. halt_i with fire at 8000_0010 -> valid_o=0 and stays 0 despite more halt_i. Redirect to 8000_2000 -> valid_o=1 at 8000_2000.
5. Four redirects in consecutive cycles -> epoch_o 1, 2, 3, 0. instAddr_o follows each target; wrap FFFF_FFF8 + 8 -> 0000_0000.
6. PCU_MISALIGN_CHK_EN on, redirect to 8000_0302 -> fault_o=1 for one cycle, valid_o=0, S_HALT. Without the macro -> packet at 8000_0300, mask 2'b11.
